// File: rtl/vga_pkg.sv
// Shared definitions for the VGA pixel fetch path.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package vga_pkg;

    // ctrl_out field positions
    localparam int CTRL_RW_BIT    = 0;
    localparam int CTRL_BURST_LSB = 1;

    // ctrl_in field positions
    localparam int CTRL_WAIT_BIT  = 0;

    // 640x480 frame
    localparam int FRAME_PIXELS_DFLT = 307200;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REQ,
        ST_XFER,
        ST_DRAIN
    } fetch_state_t;

endpackage

// File: rtl/pixel_fifo.sv
// Synchronous first-word-fall-through pixel FIFO with single-cycle flush.
// Latency: a write at edge N is visible on data after edge N; output is 0 when empty.
// Backpressure: writes while full and reads while empty are ignored; flush beats both.
module pixel_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   wr_en,
    input  logic [WIDTH-1:0]       wr_data,
    input  logic                   rd_en,
    input  logic                   flush,
    output logic [WIDTH-1:0]       data,
    output logic [$clog2(DEPTH):0] count,
    output logic                   empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q,  count_d;
    logic             do_wr;
    logic             do_rd;

    assign empty = (count_q == '0);
    assign count = count_q;
    assign data  = empty ? '0 : mem_q[rd_ptr_q];
    assign do_wr = wr_en && (count_q != (AW+1)'(DEPTH));
    assign do_rd = rd_en && !empty;

    // Pointer and occupancy update; flush returns everything to empty.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_wr) begin
                wr_ptr_d = wr_ptr_q + AW'(1);
            end
            if (do_rd) begin
                rd_ptr_d = rd_ptr_q + AW'(1);
            end
            count_d = count_q + (AW+1)'(do_wr) - (AW+1)'(do_rd);
        end
    end

    // Pointer/occupancy registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage array; contents are don't-care while the slot is unoccupied.
    always_ff @(posedge clk) begin
        if (do_wr && !flush) begin
            mem_q[wr_ptr_q] <= wr_data;
        end
    end

endmodule

// File: rtl/vga_pixel_fetch.sv
// Burst-reads framebuffer words over the system bus into a pixel FIFO feeding the scan-out path.
// Latency: bus_req 1 cycle after space frees; a bus word sampled at edge N is on pixel_out after edge N+1.
// Backpressure: bursts start only with a full burst of free space; bus_wait stalls capture; empty reads flag underrun.
module vga_pixel_fetch
    import vga_pkg::*;
#(
    parameter int COLOR_DEPTH  = 8,
    parameter int BUS_WIDTH    = 32,
    parameter int CTRL_WIDTH   = 8,
    parameter int FIFO_DEPTH   = 16,
    parameter int BURST_LEN    = 8,
    parameter int FB_BASE      = 0,
    parameter int FRAME_PIXELS = FRAME_PIXELS_DFLT
) (
    input  logic                   clk25MHz,
    input  logic                   reset_L,
    input  logic                   frame_start,
    input  logic                   pixel_rd,
    output logic [COLOR_DEPTH-1:0] pixel_out,
    output logic                   underrun,
    output logic                   bus_req,
    input  logic                   bus_ack,
    input  logic [CTRL_WIDTH-1:0]  ctrl_in,
    input  logic [BUS_WIDTH-1:0]   bus_in,
    output logic [CTRL_WIDTH-1:0]  ctrl_out,
    output logic [BUS_WIDTH-1:0]   bus_out
);

    localparam int FCW = $clog2(FIFO_DEPTH) + 1;
    localparam int OW  = FCW + 1;
    localparam int WCW = $clog2(BURST_LEN + 1);

    localparam logic [BUS_WIDTH-1:0]  BASE_ADDR = BUS_WIDTH'(FB_BASE);
    localparam logic [BUS_WIDTH-1:0]  FRAME_END = BUS_WIDTH'(FB_BASE + FRAME_PIXELS);
    // Read command: rw bit cleared, burst field carries BURST_LEN-1.
    localparam logic [CTRL_WIDTH-1:0] CTRL_RD   =
        (CTRL_WIDTH'(BURST_LEN - 1) << CTRL_BURST_LSB) & ~(CTRL_WIDTH'(1) << CTRL_RW_BIT);

    fetch_state_t           state_q,      state_d;
    logic [WCW-1:0]         word_cnt_q,   word_cnt_d;
    logic [BUS_WIDTH-1:0]   fetch_addr_q, fetch_addr_d;
    logic [BUS_WIDTH-1:0]   bus_out_q,    bus_out_d;
    logic                   wr_vld_q,     wr_vld_d;
    logic [COLOR_DEPTH-1:0] wr_dat_q,     wr_dat_d;
    logic                   underrun_q,   underrun_d;

    logic [COLOR_DEPTH-1:0] fifo_data;
    logic [FCW-1:0]         fifo_count;
    logic                   fifo_empty;

    logic                   bus_wait;
    logic                   burst_last;
    logic [OW-1:0]          occupancy;
    logic                   free_ok;
    logic [BUS_WIDTH-1:0]   addr_inc;
    logic [BUS_WIDTH-1:0]   addr_next;
    logic                   unused_bus_bits;

    assign bus_wait        = ctrl_in[CTRL_WAIT_BIT];
    assign unused_bus_bits = ^{ctrl_in[CTRL_WIDTH-1:1], bus_in[BUS_WIDTH-1:COLOR_DEPTH]};

    // The word held in the capture register is already committed, so it counts as occupied.
    assign occupancy  = OW'(fifo_count) + OW'(wr_vld_q);
    assign free_ok    = (OW'(FIFO_DEPTH) - occupancy) >= OW'(BURST_LEN);
    assign burst_last = (word_cnt_q == WCW'(BURST_LEN - 1)) && !bus_wait;
    assign addr_inc   = fetch_addr_q + BUS_WIDTH'(BURST_LEN);
    assign addr_next  = (addr_inc == FRAME_END) ? BASE_ADDR : addr_inc;

    assign bus_req   = (state_q != ST_IDLE);
    assign ctrl_out  = bus_req ? CTRL_RD : '0;
    assign bus_out   = bus_out_q;
    assign underrun  = underrun_q;
    assign pixel_out = fifo_data;

    // Burst sequencing, address advance, word capture and frame restart.
    always_comb begin
        state_d      = state_q;
        word_cnt_d   = word_cnt_q;
        fetch_addr_d = fetch_addr_q;
        bus_out_d    = bus_out_q;
        wr_vld_d     = 1'b0;
        wr_dat_d     = wr_dat_q;
        underrun_d   = underrun_q;

        case (state_q)
            ST_IDLE: begin
                if (free_ok && !frame_start) begin
                    state_d   = ST_REQ;
                    bus_out_d = fetch_addr_q;
                end
            end
            ST_REQ: begin
                if (bus_ack) begin
                    // A grant coinciding with a restart returns stale-frame data: discard it.
                    state_d    = frame_start ? ST_DRAIN : ST_XFER;
                    word_cnt_d = '0;
                end
            end
            ST_XFER: begin
                if (!bus_wait) begin
                    word_cnt_d = word_cnt_q + WCW'(1);
                    if (!frame_start) begin
                        wr_vld_d = 1'b1;
                        wr_dat_d = bus_in[COLOR_DEPTH-1:0];
                    end
                end
                if (burst_last) begin
                    state_d      = ST_IDLE;
                    fetch_addr_d = addr_next;
                end else if (frame_start) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (!bus_wait) begin
                    word_cnt_d = word_cnt_q + WCW'(1);
                end
                if (burst_last) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (frame_start) begin
            fetch_addr_d = BASE_ADDR;
            underrun_d   = 1'b0;
            if (state_q == ST_REQ && !bus_ack) begin
                bus_out_d = BASE_ADDR;
            end
        end else if (pixel_rd && fifo_empty) begin
            underrun_d = 1'b1;
        end
    end

    // Control and capture registers; reset abandons any burst in flight.
    always_ff @(posedge clk25MHz or negedge reset_L) begin
        if (!reset_L) begin
            state_q      <= ST_IDLE;
            word_cnt_q   <= '0;
            fetch_addr_q <= BASE_ADDR;
            bus_out_q    <= '0;
            wr_vld_q     <= 1'b0;
            wr_dat_q     <= '0;
            underrun_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            word_cnt_q   <= word_cnt_d;
            fetch_addr_q <= fetch_addr_d;
            bus_out_q    <= bus_out_d;
            wr_vld_q     <= wr_vld_d;
            wr_dat_q     <= wr_dat_d;
            underrun_q   <= underrun_d;
        end
    end

    pixel_fifo #(
        .WIDTH (COLOR_DEPTH),
        .DEPTH (FIFO_DEPTH)
    ) u_pixel_fifo (
        .clk     (clk25MHz),
        .rst_n   (reset_L),
        .wr_en   (wr_vld_q),
        .wr_data (wr_dat_q),
        .rd_en   (pixel_rd),
        .flush   (frame_start),
        .data    (fifo_data),
        .count   (fifo_count),
        .empty   (fifo_empty)
    );

endmodule
